// File: rtl/seq_regmap_pkg.sv
// Shared register-map definitions for the DFX sequencer AXI-Lite slaves:
// FSM encodings, bank selectors, register offsets and slot-table row packing.
package seq_regmap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_FETCH = 3'b001,
    ST_RESP  = 3'b010
  } rd_state_e;

  localparam logic [1:0] BANK_SEL_0 = 2'b00;
  localparam logic [1:0] BANK_SEL_1 = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Bank0 register offsets, decoded on addr[13:6]
  localparam logic [7:0] B0_CONTROL       = 8'h00;
  localparam logic [7:0] B0_STATUS        = 8'h01;
  localparam logic [7:0] B0_CUR_CNT       = 8'h02;
  localparam logic [7:0] B0_END_CNT       = 8'h03;
  localparam logic [7:0] B0_DMA_BASE_ADDR = 8'h04;
  localparam logic [7:0] B0_DFX_CTRL_ADDR = 8'h05;

  // Bank1 field offsets within a slot row, decoded on addr[5:2]
  localparam logic [3:0] B1_SRC_ADDR         = 4'h0;
  localparam logic [3:0] B1_SRC_SIZE         = 4'h1;
  localparam logic [3:0] B1_DES_ADDR         = 4'h2;
  localparam logic [3:0] B1_DES_SIZE         = 4'h3;
  localparam logic [3:0] B1_STATUS           = 4'h4;
  localparam logic [3:0] B1_PROFILE          = 4'h5;
  localparam logic [3:0] B1_LD_MASK          = 4'h6;
  localparam logic [3:0] B1_ST_MASK          = 4'h7;
  localparam logic [3:0] B1_ST_INTR_MASK_ABS = 4'h8;

  localparam int unsigned W_SRC_ADDR         = 32;
  localparam int unsigned W_SRC_SIZE         = 26;
  localparam int unsigned W_DES_ADDR         = 32;
  localparam int unsigned W_DES_SIZE         = 26;
  localparam int unsigned W_STATUS           = 2;
  localparam int unsigned W_PROFILE          = 32;
  localparam int unsigned W_LD_MASK          = 8;
  localparam int unsigned W_ST_MASK          = 8;
  localparam int unsigned W_ST_INTR_MASK_ABS = 8;

  // Row packing: src_addr sits at the LSB, st_intr_mask_abs at the MSB
  localparam int unsigned LSB_SRC_ADDR         = 0;
  localparam int unsigned LSB_SRC_SIZE         = LSB_SRC_ADDR + W_SRC_ADDR;
  localparam int unsigned LSB_DES_ADDR         = LSB_SRC_SIZE + W_SRC_SIZE;
  localparam int unsigned LSB_DES_SIZE         = LSB_DES_ADDR + W_DES_ADDR;
  localparam int unsigned LSB_STATUS           = LSB_DES_SIZE + W_DES_SIZE;
  localparam int unsigned LSB_PROFILE          = LSB_STATUS + W_STATUS;
  localparam int unsigned LSB_LD_MASK          = LSB_PROFILE + W_PROFILE;
  localparam int unsigned LSB_ST_MASK          = LSB_LD_MASK + W_LD_MASK;
  localparam int unsigned LSB_ST_INTR_MASK_ABS = LSB_ST_MASK + W_ST_MASK;

  localparam int unsigned BANK1_ROW_WIDTH = LSB_ST_INTR_MASK_ABS + W_ST_INTR_MASK_ABS;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/s_axi_read_if.sv
// AXI4-Lite read channels (AR + R) between the interconnect master and the read slave.
interface s_axi_read_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
  logic                  S_AXI_ARVALID;
  logic                  S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0] S_AXI_RDATA;
  logic [1:0]            S_AXI_RRESP;
  logic                  S_AXI_RVALID;
  logic                  S_AXI_RREADY;

  modport master (
    output S_AXI_ARADDR,
    output S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA,
    input  S_AXI_RRESP,
    input  S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_ARADDR,
    input  S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA,
    output S_AXI_RRESP,
    output S_AXI_RVALID,
    input  S_AXI_RREADY
  );

endinterface

// File: rtl/seq_rd_decode.sv
// Combinational read decode: maps a latched address onto a bank0 register or a bank1
// slot-row field, zero-extended/truncated to the bus width, with SLVERR for holes.
module seq_rd_decode
  import seq_regmap_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH          = 16,
  parameter int unsigned DATA_WIDTH          = 32,
  parameter int unsigned GLOB_ADDR_WIDTH     = 32,
  parameter int unsigned BANK1_INDEX_WIDTH   = 3,
  parameter int unsigned BANK0_CONTROL_WIDTH = 4,
  parameter int unsigned BANK0_STATUS_WIDTH  = 4
) (
  input  logic [ADDR_WIDTH-1:0]          addr_i,
  input  logic [BANK1_ROW_WIDTH-1:0]     row_i,
  input  logic [BANK0_CONTROL_WIDTH-1:0] control_i,
  input  logic [BANK0_STATUS_WIDTH-1:0]  status_i,
  input  logic [BANK1_INDEX_WIDTH-1:0]   cur_cnt_i,
  input  logic [BANK1_INDEX_WIDTH-1:0]   end_cnt_i,
  input  logic [GLOB_ADDR_WIDTH-1:0]     dma_base_addr_i,
  input  logic [GLOB_ADDR_WIDTH-1:0]     dfx_ctrl_addr_i,
  output logic [DATA_WIDTH-1:0]          data_o,
  output logic [1:0]                     resp_o,
  output logic                           status_hit_o
);

  // Staging vector wide enough for any source; the bus takes its low DATA_WIDTH bits.
  localparam int unsigned WideW = max_u(max_u(DATA_WIDTH, GLOB_ADDR_WIDTH),
                                        max_u(32, max_u(BANK0_CONTROL_WIDTH,
                                                        BANK0_STATUS_WIDTH)));

  logic [WideW-1:0] val;
  logic             err;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^addr_i[1:0];

  always_comb begin
    val          = '0;
    err          = 1'b0;
    status_hit_o = 1'b0;
    case (addr_i[15:14])
      BANK_SEL_0: begin
        case (addr_i[13:6])
          B0_CONTROL:       val[BANK0_CONTROL_WIDTH-1:0] = control_i;
          B0_STATUS: begin
            val[BANK0_STATUS_WIDTH-1:0] = status_i;
            status_hit_o                = 1'b1;
          end
          B0_CUR_CNT:       val[BANK1_INDEX_WIDTH-1:0] = cur_cnt_i;
          B0_END_CNT:       val[BANK1_INDEX_WIDTH-1:0] = end_cnt_i;
          B0_DMA_BASE_ADDR: val[GLOB_ADDR_WIDTH-1:0]   = dma_base_addr_i;
          B0_DFX_CTRL_ADDR: val[GLOB_ADDR_WIDTH-1:0]   = dfx_ctrl_addr_i;
          default:          err = 1'b1;
        endcase
      end
      BANK_SEL_1: begin
        // Row bits above the index select slots that do not exist
        if (addr_i[13:BANK1_INDEX_WIDTH+6] != '0) begin
          err = 1'b1;
        end else begin
          case (addr_i[5:2])
            B1_SRC_ADDR:  val[W_SRC_ADDR-1:0] = row_i[LSB_SRC_ADDR +: W_SRC_ADDR];
            B1_SRC_SIZE:  val[W_SRC_SIZE-1:0] = row_i[LSB_SRC_SIZE +: W_SRC_SIZE];
            B1_DES_ADDR:  val[W_DES_ADDR-1:0] = row_i[LSB_DES_ADDR +: W_DES_ADDR];
            B1_DES_SIZE:  val[W_DES_SIZE-1:0] = row_i[LSB_DES_SIZE +: W_DES_SIZE];
            B1_STATUS:    val[W_STATUS-1:0]   = row_i[LSB_STATUS +: W_STATUS];
            B1_PROFILE:   val[W_PROFILE-1:0]  = row_i[LSB_PROFILE +: W_PROFILE];
            B1_LD_MASK:   val[W_LD_MASK-1:0]  = row_i[LSB_LD_MASK +: W_LD_MASK];
            B1_ST_MASK:   val[W_ST_MASK-1:0]  = row_i[LSB_ST_MASK +: W_ST_MASK];
            B1_ST_INTR_MASK_ABS:
              val[W_ST_INTR_MASK_ABS-1:0] = row_i[LSB_ST_INTR_MASK_ABS +: W_ST_INTR_MASK_ABS];
            default:      err = 1'b1;
          endcase
        end
      end
      default: err = 1'b1;
    endcase
    data_o = val[DATA_WIDTH-1:0];
    resp_o = err ? RESP_SLVERR : RESP_OKAY;
  end

endmodule

// File: rtl/s_axi_read.sv
// AXI4-Lite read slave for the DFX sequencer register map: IDLE -> FETCH -> RESP,
// one outstanding read, registered RDATA/RRESP, status read-to-clear pulse.
module s_axi_read
  import seq_regmap_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH          = 16,
  parameter int unsigned DATA_WIDTH          = 32,
  parameter int unsigned GLOB_ADDR_WIDTH     = 32,
  parameter int unsigned BANK1_INDEX_WIDTH   = 3,
  parameter int unsigned BANK0_CONTROL_WIDTH = 4,
  parameter int unsigned BANK0_STATUS_WIDTH  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  s_axi_read_if.slave                    s_axi,
  output logic [BANK1_INDEX_WIDTH-1:0]   ext_bank1_rd_index,
  input  logic [BANK1_ROW_WIDTH-1:0]     ext_bank1_rd_row,
  input  logic [BANK0_CONTROL_WIDTH-1:0] ext_bank0_control,
  input  logic [BANK0_STATUS_WIDTH-1:0]  ext_bank0_status,
  input  logic [BANK1_INDEX_WIDTH-1:0]   ext_bank0_curCnt,
  input  logic [BANK1_INDEX_WIDTH-1:0]   ext_bank0_endCnt,
  input  logic [GLOB_ADDR_WIDTH-1:0]     ext_bank0_dmaBaseAddr,
  input  logic [GLOB_ADDR_WIDTH-1:0]     ext_bank0_dfxCtrlAddr,
  output logic                           ext_bank0_status_rd
);

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic [DATA_WIDTH-1:0] dec_data;
  logic [1:0]            dec_resp;
  logic                  dec_status_hit;

  seq_rd_decode #(
    .ADDR_WIDTH          (ADDR_WIDTH),
    .DATA_WIDTH          (DATA_WIDTH),
    .GLOB_ADDR_WIDTH     (GLOB_ADDR_WIDTH),
    .BANK1_INDEX_WIDTH   (BANK1_INDEX_WIDTH),
    .BANK0_CONTROL_WIDTH (BANK0_CONTROL_WIDTH),
    .BANK0_STATUS_WIDTH  (BANK0_STATUS_WIDTH)
  ) u_decode (
    .addr_i          (rd_addr_q),
    .row_i           (ext_bank1_rd_row),
    .control_i       (ext_bank0_control),
    .status_i        (ext_bank0_status),
    .cur_cnt_i       (ext_bank0_curCnt),
    .end_cnt_i       (ext_bank0_endCnt),
    .dma_base_addr_i (ext_bank0_dmaBaseAddr),
    .dfx_ctrl_addr_i (ext_bank0_dfxCtrlAddr),
    .data_o          (dec_data),
    .resp_o          (dec_resp),
    .status_hit_o    (dec_status_hit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      rd_addr_q <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (state_q)
      ST_IDLE: begin
        if (s_axi.S_AXI_ARVALID) begin
          rd_addr_d = s_axi.S_AXI_ARADDR;
          state_d   = ST_FETCH;
        end
      end
      // Bank contents are sampled here only; RDATA is frozen for the rest of the read
      ST_FETCH: begin
        rdata_d = dec_data;
        rresp_d = dec_resp;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (s_axi.S_AXI_RREADY) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_axi.S_AXI_ARREADY = (state_q == ST_IDLE);
    s_axi.S_AXI_RVALID  = (state_q == ST_RESP);
    s_axi.S_AXI_RDATA   = rdata_q;
    s_axi.S_AXI_RRESP   = rresp_q;
    ext_bank0_status_rd = (state_q == ST_FETCH) && dec_status_hit;
  end

  assign ext_bank1_rd_index = rd_addr_q[BANK1_INDEX_WIDTH+5:6];

endmodule

// File: tb/tb_s_axi_read.sv
// Self-checking bench for s_axi_read: directed vector table, stall/reset sequences and
// randomized reads against a register-map model built from per-slot field arrays.
module tb_s_axi_read;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [2:0]   rd_index;
  logic [173:0] row;
  logic [3:0]   ctrl, stat;
  logic [2:0]   cur_cnt, end_cnt;
  logic [31:0]  dma, dfx;
  logic         status_rd;
  logic [31:0]  slot_f [8][9];

  int n_checks = 0;
  int n_fail   = 0;
  int srd_cnt  = 0;

  s_axi_read_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) axi ();

  s_axi_read dut (
    .clk                   (clk),
    .reset                 (reset),
    .s_axi                 (axi),
    .ext_bank1_rd_index    (rd_index),
    .ext_bank1_rd_row      (row),
    .ext_bank0_control     (ctrl),
    .ext_bank0_status      (stat),
    .ext_bank0_curCnt      (cur_cnt),
    .ext_bank0_endCnt      (end_cnt),
    .ext_bank0_dmaBaseAddr (dma),
    .ext_bank0_dfxCtrlAddr (dfx),
    .ext_bank0_status_rd   (status_rd)
  );

  function automatic int fw(input int f);
    case (f)
      0, 2, 5: return 32;
      1, 3:    return 26;
      4:       return 2;
      default: return 8;
    endcase
  endfunction

  // Bank1 register file: the selected slot's fields packed LSB-first
  always_comb begin
    int off;
    row = '0;
    off = 0;
    for (int f = 0; f < 9; f++) begin
      for (int b = 0; b < 32; b++) begin
        if (b < fw(f)) row[off+b] = slot_f[rd_index][f][b];
      end
      off = off + fw(f);
    end
  end

  always @(negedge clk) if (status_rd) srd_cnt <= srd_cnt + 1;

  function automatic void model(input logic [15:0] a, output logic [31:0] d,
                                output logic [1:0] r);
    logic [63:0] mask;
    int          f;
    d = 32'h0;
    r = 2'b10;
    if (a[15:14] == 2'b00) begin
      r = 2'b00;
      case (a[13:6])
        8'd0:    d = 32'(ctrl);
        8'd1:    d = 32'(stat);
        8'd2:    d = 32'(cur_cnt);
        8'd3:    d = 32'(end_cnt);
        8'd4:    d = dma;
        8'd5:    d = dfx;
        default: r = 2'b10;
      endcase
    end else if (a[15:14] == 2'b01 && a[13:9] == 5'd0 && a[5:2] < 4'd9) begin
      f    = int'(a[5:2]);
      mask = (64'd1 << fw(f)) - 64'd1;
      d    = 32'(64'(slot_f[a[8:6]][f]) & mask);
      r    = 2'b00;
    end
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Entered and left on a negedge with the DUT idle
  task automatic do_read(input logic [15:0] a, input int rdly, output logic [31:0] d,
                         output logic [1:0] r, output int lat, output logic [2:0] idx);
    int n;
    axi.S_AXI_ARADDR  = a;
    axi.S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!axi.S_AXI_ARREADY && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("arready_timeout", 64'(axi.S_AXI_ARREADY), 64'd1);
    @(negedge clk);
    axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_ARADDR  = 16'($urandom);
    idx = rd_index;
    lat = 1;
    while (!axi.S_AXI_RVALID && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    repeat (rdly) @(negedge clk);
    d = axi.S_AXI_RDATA;
    r = axi.S_AXI_RRESP;
    axi.S_AXI_RREADY = 1'b1;
    @(negedge clk);
    axi.S_AXI_RREADY = 1'b0;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
    int          srd;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic [31:0] d, ed;
    logic [1:0]  r, er;
    logic [2:0]  idx;
    logic [15:0] a;
    int          lat, s0, kind;

    reset = 1'b0;
    axi.S_AXI_ARADDR  = '0;
    axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY  = 1'b0;
    ctrl = 4'hA; stat = 4'h5; cur_cnt = 3'd6; end_cnt = 3'd7;
    dma = 32'h1234_5678; dfx = 32'h8765_4321;
    for (int s = 0; s < 8; s++) for (int f = 0; f < 9; f++) slot_f[s][f] = $urandom;
    slot_f[3][5] = 32'hDEAD_BEEF;
    slot_f[1][1] = 32'hFFFF_FFFF;
    slot_f[1][4] = 32'hFFFF_FFFF;
    slot_f[7][8] = 32'h0000_01FF;

    vecs[0]  = '{16'h0000, 32'h0000_000A, 2'b00, 0};
    vecs[1]  = '{16'h0040, 32'h0000_0005, 2'b00, 1};
    vecs[2]  = '{16'h0080, 32'h0000_0006, 2'b00, 0};
    vecs[3]  = '{16'h00C0, 32'h0000_0007, 2'b00, 0};
    vecs[4]  = '{16'h0100, 32'h1234_5678, 2'b00, 0};
    vecs[5]  = '{16'h0140, 32'h8765_4321, 2'b00, 0};
    vecs[6]  = '{16'h0180, 32'h0000_0000, 2'b10, 0};
    vecs[7]  = '{16'h8000, 32'h0000_0000, 2'b10, 0};
    vecs[8]  = '{16'hC000, 32'h0000_0000, 2'b10, 0};
    vecs[9]  = '{16'h40D4, 32'hDEAD_BEEF, 2'b00, 0};
    vecs[10] = '{16'h4044, 32'h03FF_FFFF, 2'b00, 0};
    vecs[11] = '{16'h4064, 32'h0000_0000, 2'b10, 0};
    vecs[12] = '{16'h4200, 32'h0000_0000, 2'b10, 0};
    vecs[13] = '{16'h0003, 32'h0000_000A, 2'b00, 0};
    vecs[14] = '{16'h41E0, 32'h0000_00FF, 2'b00, 0};

    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_arready", 64'(axi.S_AXI_ARREADY), 64'd1);
    check("reset_rvalid", 64'(axi.S_AXI_RVALID), 64'd0);
    check("reset_rdata", 64'(axi.S_AXI_RDATA), 64'd0);
    check("reset_rresp", 64'(axi.S_AXI_RRESP), 64'd0);
    check("reset_status_rd", 64'(status_rd), 64'd0);
    check("reset_rd_index", 64'(rd_index), 64'd0);

    foreach (vecs[i]) begin
      s0 = srd_cnt;
      do_read(vecs[i].addr, 0, d, r, lat, idx);
      check($sformatf("vec%0d_rdata", i), 64'(d), 64'(vecs[i].data));
      check($sformatf("vec%0d_rresp", i), 64'(r), 64'(vecs[i].resp));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
      check($sformatf("vec%0d_status_rd", i), 64'(srd_cnt - s0), 64'(vecs[i].srd));
      if (vecs[i].addr == 16'h40D4) check("vec_rd_index_fetch", 64'(idx), 64'd3);
    end

    // RREADY stall with a competing ARVALID and a bank1 write after FETCH
    axi.S_AXI_ARADDR = 16'h40D4;
    axi.S_AXI_ARVALID = 1'b1;
    @(negedge clk);
    axi.S_AXI_ARVALID = 1'b0;
    @(negedge clk);
    check("stall_rvalid_up", 64'(axi.S_AXI_RVALID), 64'd1);
    slot_f[3][5] = 32'h0BAD_F00D;
    axi.S_AXI_ARADDR = 16'h0000;
    axi.S_AXI_ARVALID = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stall_arready", 64'(axi.S_AXI_ARREADY), 64'd0);
      check("stall_rvalid", 64'(axi.S_AXI_RVALID), 64'd1);
      check("stall_rdata", 64'(axi.S_AXI_RDATA), 64'hDEAD_BEEF);
    end
    axi.S_AXI_RREADY = 1'b1;
    @(negedge clk);
    axi.S_AXI_RREADY = 1'b0;
    check("post_hs_arready", 64'(axi.S_AXI_ARREADY), 64'd1);
    check("post_hs_rvalid", 64'(axi.S_AXI_RVALID), 64'd0);
    @(negedge clk);
    axi.S_AXI_ARVALID = 1'b0;
    @(negedge clk);
    check("queued_rvalid", 64'(axi.S_AXI_RVALID), 64'd1);
    check("queued_rdata", 64'(axi.S_AXI_RDATA), 64'h0000_000A);
    axi.S_AXI_RREADY = 1'b1;
    @(negedge clk);
    axi.S_AXI_RREADY = 1'b0;
    slot_f[3][5] = 32'hDEAD_BEEF;

    // Reset while a response is pending
    axi.S_AXI_ARADDR = 16'h0100;
    axi.S_AXI_ARVALID = 1'b1;
    @(negedge clk);
    axi.S_AXI_ARVALID = 1'b0;
    @(negedge clk);
    check("rst_pre_rvalid", 64'(axi.S_AXI_RVALID), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("rst_async_rvalid", 64'(axi.S_AXI_RVALID), 64'd0);
    check("rst_async_arready", 64'(axi.S_AXI_ARREADY), 64'd1);
    check("rst_async_rdata", 64'(axi.S_AXI_RDATA), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_read(16'h0100, 0, d, r, lat, idx);
    check("rst_after_rdata", 64'(d), 64'h1234_5678);
    check("rst_after_rresp", 64'(r), 64'd0);
    check("rst_after_latency", 64'(lat), 64'd2);

    for (int it = 0; it < 300; it++) begin
      ctrl = 4'($urandom); stat = 4'($urandom);
      cur_cnt = 3'($urandom); end_cnt = 3'($urandom);
      dma = $urandom; dfx = $urandom;
      slot_f[$urandom_range(0, 7)][$urandom_range(0, 8)] = $urandom;
      a = 16'($urandom);
      kind = $urandom_range(0, 9);
      if (kind <= 3) begin
        a[15:14] = 2'b00;
        a[13:6]  = 8'($urandom_range(0, 7));
      end else if (kind <= 8) begin
        a[15:14] = 2'b01;
        if (kind <= 7) a[13:9] = 5'd0;
        else if (a[13:9] == 5'd0) a[11] = 1'b1;
      end else if (a[15:14] < 2'b10) begin
        a[15] = 1'b1;
      end
      model(a, ed, er);
      s0 = srd_cnt;
      do_read(a, $urandom_range(0, 3), d, r, lat, idx);
      check($sformatf("rnd_rdata a=%04h", a), 64'(d), 64'(ed));
      check($sformatf("rnd_rresp a=%04h", a), 64'(r), 64'(er));
      check($sformatf("rnd_latency a=%04h", a), 64'(lat), 64'd2);
      check($sformatf("rnd_rd_index a=%04h", a), 64'(idx), 64'(a[8:6]));
      check($sformatf("rnd_status_rd a=%04h", a), 64'(srd_cnt - s0),
            (a[15:14] == 2'b00 && a[13:6] == 8'd1) ? 64'd1 : 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
